// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the sequential chunked ripple-carry adder.
// Optional subtract support is selected with RCA_SUB_EN (see seq_chunk_adder).
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a counter over n slices; never narrower than one bit.
  function automatic int idx_width(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The sub select line exists only when RCA_SUB_EN is defined.
interface seq_chunk_adder_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef RCA_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple of full adders; one instance serves
// whichever slice the sequencer currently selects.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder adding one CHUNK-bit slice per clock.
// Define RCA_SUB_EN to add the sub select (a-b via ~b and forced carry-in).
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_chunk_adder_if.slave    bus,
  output logic                busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [IDXW-1:0]  idx_q;
  logic             accept;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // in_ready in DONE depends on out_ready so a new operand can land on the same edge the result is taken.
  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (idx_q == LAST) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            accept     = 1'b1;
            next_state = CALC;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (s_sl),
    .cout (c_sl)
  );

  // sum is only ever overwritten slice by slice, so it keeps the last result while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      idx_q <= '0;
`ifdef RCA_SUB_EN
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub | bus.cin;
`else
      b_q     <= bus.b;
      carry_q <= bus.cin;
`endif
    end else if (state == CALC) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (idx_q == IDXW'(i)) sum_q[i*CHUNK +: CHUNK] <= s_sl;
      end
      carry_q <= c_sl;
      if (idx_q == LAST) begin
        cout_q <= c_sl;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomised self-checking bench for seq_chunk_adder (16/4 instance plus a 4/1 sweep instance).
// Exercises subtraction as well when RCA_SUB_EN is defined.
module tb_seq_chunk_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, sbusy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();
  seq_chunk_adder_if #(.WIDTH(4))     sbus ();

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave),
    .busy  (sbusy)
  );

  // Reference: plain integer add, or difference with "no borrow" as carry out.
  function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
    logic [WIDTH-1:0] d;
    if (sub) begin
      d = a - b;
      return {(a >= b), d};
    end
    return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer operands and return #1 after the edge that accepted them.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int waitc;
    waitc = 0;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("acceptInTime", 32'(waitc < 50), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int k;
    k = 0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({tag, "_latency"}, 32'(k), 32'(NCHUNK));
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
    logic [WIDTH:0] e;
    e = refResult(a, b, cin, sub);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(e[WIDTH-1:0]));
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(e[WIDTH]));
  endtask

  task automatic takeResult(input string tag, input logic [WIDTH-1:0] exp_sum);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_validDrop"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_sumHeld"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input int hold);
    logic [WIDTH:0] e;
    e = refResult(a, b, cin, sub);
`ifdef RCA_SUB_EN
    bus.sub = sub;
`endif
    applyStimulus(a, b, cin);
    waitResult(tag);
    checkResult(tag, a, b, cin, sub);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_validHeld"}, 32'(bus.out_valid), 32'd1);
    takeResult(tag, e[WIDTH-1:0]);
  endtask

  task automatic runSmall(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int k;
    logic [4:0] e;
    e = 5'(a) + 5'(b) + 5'(cin);
    sbus.a = a;
    sbus.b = b;
    sbus.cin = cin;
    sbus.in_valid = 1'b1;
    sbus.out_ready = 1'b1;
    #1;
    k = 0;
    while (!sbus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    k = 0;
    while (!sbus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("small_latency", 32'(k), 32'd4);
    checkOutput("small_result", 32'({sbus.cout, sbus.sum}), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs, seen;

    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;
    sbus.in_valid = 1'b0; sbus.out_ready = 1'b0;
    sbus.a = '0; sbus.b = '0; sbus.cin = 1'b0;
`ifdef RCA_SUB_EN
    bus.sub = 1'b0;
    sbus.sub = 1'b0;
`endif

    #2;
    checkOutput("rst_sum", 32'(bus.sum), 32'd0);
    checkOutput("rst_cout", 32'(bus.cout), 32'd0);
    checkOutput("rst_outValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_inReady", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    runOp("carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    runOp("rippleAll", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);

    // Backpressure, then a new operand accepted on the edge the result is taken.
    applyStimulus(16'hABCD, 16'h1234, 1'b1);
    waitResult("bp");
    checkResult("bp", 16'hABCD, 16'h1234, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_validStable", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_inReadyLow", 32'(bus.in_ready), 32'd0);
      checkResult("bp_hold", 16'hABCD, 16'h1234, 1'b1, 1'b0);
    end
    bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_inReadyTaken", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checkOutput("bp_straightToCalc", 32'(busy), 32'd1);
    checkOutput("bp_validCleared", 32'(bus.out_valid), 32'd0);
    waitResult("bp2");
    checkResult("bp2", 16'h8000, 16'h8000, 1'b1, 1'b0);
    takeResult("bp2", 16'h0001);

    // Reset during the second CALC cycle discards the operation.
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_sum", 32'(bus.sum), 32'd0);
    checkOutput("midRst_cout", 32'(bus.cout), 32'd0);
    checkOutput("midRst_outValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput("midRst_noValid", 32'(seen), 32'd0);
    checkOutput("midRst_sumIdle", 32'(bus.sum), 32'd0);

`ifdef RCA_SUB_EN
    runOp("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    runOp("sub7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    runOp("subCinIgnored", 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 8 == 0) rb = ~ra;
      rc = 1'($urandom);
`ifdef RCA_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      runOp("rand", ra, rb, rc, rs, int'($urandom_range(0, 3)));
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          runSmall(4'(a), 4'(b), 1'(c));
    sbus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
